// File: rtl/store_narrower.sv
// Narrows a 32-bit register value to byte/halfword/word and writes it
// little-endian, one byte per handshake, to a byte-wide memory port.
module store_narrower #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_data,
   input  logic [1:0]        req_size,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data,
   output logic              busy,
   output logic              done,
   output logic              fit_err,
   output logic              align_err
);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      DONE
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] base_q;
   logic [31:0]       data_q;
   logic [1:0]        idx_q;
   logic [1:0]        last_q;
   logic              fit_q;
   logic              align_q;

   logic              accept;
   logic              req_align_err;
   logic              req_fit_err;
   logic              last_byte;

   assign accept    = req_valid & req_ready;
   assign last_byte = (idx_q == last_q);

   always_comb begin
      req_align_err = (req_size == 2'b11)
                    | ((req_size == 2'b01) & req_addr[0])
                    | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
      case (req_size)
         2'b00:   req_fit_err = (req_data[31:8]  != {24{req_data[7]}});
         2'b01:   req_fit_err = (req_data[31:16] != {16{req_data[15]}});
         default: req_fit_err = 1'b0;
      endcase
      // A rejected request never reports a fit problem.
      if (req_align_err) req_fit_err = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = req_align_err ? DONE : SEND;
         SEND: if (mem_ready && last_byte) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         base_q  <= '0;
         data_q  <= '0;
         idx_q   <= '0;
         last_q  <= '0;
         fit_q   <= 1'b0;
         align_q <= 1'b0;
      end else if (accept) begin
         base_q  <= req_addr;
         data_q  <= req_data;
         idx_q   <= '0;
         case (req_size)
            2'b00:   last_q <= 2'd0;
            2'b01:   last_q <= 2'd1;
            default: last_q <= 2'd3;
         endcase
         fit_q   <= req_fit_err;
         align_q <= req_align_err;
      end else if (state == SEND && mem_ready && !last_byte) begin
         idx_q <= idx_q + 2'd1;
      end
   end

   always_comb begin
      req_ready = (state == IDLE) & ~reset;
      mem_valid = (state == SEND);
      busy      = (state != IDLE);
      done      = (state == DONE);
      fit_err   = done & fit_q;
      align_err = done & align_q;
      mem_addr  = '0;
      mem_data  = '0;
      if (mem_valid) begin
         mem_addr = base_q + ADDR_W'(idx_q);
         mem_data = data_q[{idx_q, 3'b000} +: 8];
      end
   end

endmodule
